// File: rtl/collatz_pkg.sv
// Shared constants and FSM encoding for the Collatz sequencer and its step unit.
package collatz_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STEP_W = 8;
    localparam int SEED_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/collatz_step.sv
// One combinational Collatz step: hold at 1, halve when even, 3n+1 when odd.
module collatz_step
    import collatz_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] next_val,
    output logic             ovf
);

    localparam logic [WIDTH+1:0] WIDE_ONE = (WIDTH+2)'(1);

    // Two guard bits make 3n+1 exact for any WIDTH-bit n, so overflow is just the top bits.
    logic [WIDTH+1:0] triple;

    always_comb begin
        triple   = ({2'b00, cur} << 1) + {2'b00, cur} + WIDE_ONE;
        next_val = cur;
        ovf      = 1'b0;
        if (cur == WIDTH'(1)) begin
            next_val = cur;
        end else if (!cur[0]) begin
            next_val = cur >> 1;
        end else begin
            next_val = triple[WIDTH-1:0];
            ovf      = |triple[WIDTH+1:WIDTH];
        end
    end

endmodule

// File: rtl/collatz_sequencer.sv
// Walks a Collatz sequence from an 8-bit seed, one step per cycle, reporting
// step count, peak value and an error flag for zero seed, overflow or step saturation.
module collatz_sequencer
    import collatz_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        start_value,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps,
    output logic [WIDTH-1:0]  peak,
    output logic              err,
    output logic [1:0]        fsm_state
);

    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] step_val;
    logic             step_ovf;
    logic             at_one;
    logic             sat;

    collatz_step #(.WIDTH(WIDTH)) u_step (
        .cur      (cur),
        .next_val (step_val),
        .ovf      (step_ovf)
    );

    assign at_one = (cur == WIDTH'(1));
    assign sat    = (steps == STEP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = (start_value == 8'd0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (at_one || sat || step_ovf) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_RUN);
        done      = (state == ST_DONE);
        fsm_state = state;
    end

    // A terminating RUN cycle (saturation or overflow) flags err but leaves cur, steps and peak as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= '0;
            steps <= '0;
            peak  <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur   <= WIDTH'(start_value);
                        steps <= '0;
                        peak  <= WIDTH'(start_value);
                        err   <= (start_value == 8'd0);
                    end
                end
                ST_RUN: begin
                    if (!at_one) begin
                        if (sat || step_ovf) begin
                            err <= 1'b1;
                        end else begin
                            cur   <= step_val;
                            steps <= steps + STEP_W'(1);
                            if (step_val > peak) peak <= step_val;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_sequencer.sv
// Bench for collatz_sequencer: default, 8-bit-value and 4-bit-step instances share clock and reset.
module tb_collatz_sequencer;
    import collatz_pkg::*;

    localparam int SB_W = 34;  // {latency[8:0], err, steps[7:0], peak[15:0]}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int         sel = 0;
    logic       start_req = 1'b0;
    logic [7:0] sv = 8'd0;

    logic        busy_a, done_a, err_a;
    logic [7:0]  steps_a;
    logic [15:0] peak_a;
    logic [1:0]  fsm_a;
    logic        busy_b, done_b, err_b;
    logic [7:0]  steps_b;
    logic [7:0]  peak_b;
    logic [1:0]  fsm_b;
    logic        busy_c, done_c, err_c;
    logic [3:0]  steps_c;
    logic [15:0] peak_c;
    logic [1:0]  fsm_c;

    collatz_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_req && sel == 0), .start_value(sv),
        .busy(busy_a), .done(done_a), .steps(steps_a), .peak(peak_a), .err(err_a), .fsm_state(fsm_a)
    );

    collatz_sequencer #(.WIDTH(8), .STEP_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_req && sel == 1), .start_value(sv),
        .busy(busy_b), .done(done_b), .steps(steps_b), .peak(peak_b), .err(err_b), .fsm_state(fsm_b)
    );

    collatz_sequencer #(.WIDTH(16), .STEP_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_req && sel == 2), .start_value(sv),
        .busy(busy_c), .done(done_c), .steps(steps_c), .peak(peak_c), .err(err_c), .fsm_state(fsm_c)
    );

    logic        o_busy, o_done, o_err;
    logic [7:0]  o_steps;
    logic [15:0] o_peak;
    logic [1:0]  o_fsm;

    always_comb begin
        o_busy = busy_a; o_done = done_a; o_err = err_a;
        o_steps = steps_a; o_peak = peak_a; o_fsm = fsm_a;
        case (sel)
            1: begin
                o_busy = busy_b; o_done = done_b; o_err = err_b;
                o_steps = steps_b; o_peak = {8'd0, peak_b}; o_fsm = fsm_b;
            end
            2: begin
                o_busy = busy_c; o_done = done_c; o_err = err_c;
                o_steps = {4'd0, steps_c}; o_peak = peak_c; o_fsm = fsm_c;
            end
            default: ;
        endcase
    end

    int vectors = 0;
    int miscompares = 0;
    logic [SB_W-1:0] exp_q[$];

    // Reference walk of the sequence with explicit value and step limits.
    function automatic logic [SB_W-1:0] model(input int seed, input int width, input int step_w);
        longint c, pk, nx, maxv, smax;
        int st;
        logic e;
        c = seed; pk = seed; st = 0; e = (seed == 0);
        maxv = (64'd1 << width) - 1;
        smax = (64'd1 << step_w) - 1;
        if (seed != 0) begin
            while (c != 1) begin
                if (st == smax) begin e = 1'b1; break; end
                nx = c[0] ? 3 * c + 1 : c >> 1;
                if (nx > maxv) begin e = 1'b1; break; end
                c = nx;
                st++;
                if (c > pk) pk = c;
            end
        end
        return {9'((seed == 0) ? 1 : st + 2), e, 8'(st), 16'(pk)};
    endfunction

    task automatic run_seed(input logic [7:0] seed, input int poke_at,
                            output int lat, output int busy_cycles);
        @(negedge clk);
        sv = seed;
        start_req = 1'b1;
        lat = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            lat++;
            start_req = (lat == poke_at);
            if (lat == poke_at) sv = 8'd6;
            if (o_busy) busy_cycles++;
        end while (!o_done && lat < 400);
        start_req = 1'b0;
    endtask

    task automatic test_reset;
        sel = 0;
        repeat (3) @(negedge clk);
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", o_busy); end
        vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", o_done); end
        vectors++; if (o_steps !== 8'd0) begin miscompares++; $display("FAIL reset_steps got %0d want 0", o_steps); end
        vectors++; if (o_peak !== 16'd0) begin miscompares++; $display("FAIL reset_peak got %0d want 0", o_peak); end
        vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", o_err); end
        vectors++; if (o_fsm !== 2'(ST_IDLE)) begin miscompares++; $display("FAIL reset_state got %0d want 0", o_fsm); end
        sv = 8'd6;
        start_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start_req = 1'b0;
        @(negedge clk);
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL start_in_reset busy got %b want 0", o_busy); end
    endtask

    task automatic test_known_seeds;
        int k_sel[6]  = '{0, 0, 0, 0, 1, 2};
        int k_seed[6] = '{1, 6, 27, 0, 27, 27};
        int k_poke[6] = '{-1, -1, 5, -1, -1, -1};
        int k_lat[6]  = '{2, 10, 113, 1, 13, 17};
        int k_st[6]   = '{0, 8, 111, 0, 11, 15};
        int k_pk[6]   = '{1, 16, 9232, 0, 214, 484};
        int k_err[6]  = '{0, 0, 0, 1, 1, 1};
        int lat, bc, e_bc;
        logic [SB_W-1:0] e;
        for (int i = 0; i < 6; i++) begin
            sel = k_sel[i];
            exp_q.push_back({9'(k_lat[i]), 1'(k_err[i]), 8'(k_st[i]), 16'(k_pk[i])});
            run_seed(8'(k_seed[i]), k_poke[i], lat, bc);
            e = exp_q.pop_front();
            e_bc = (k_seed[i] == 0) ? 0 : int'(e[33:25]) - 1;
            vectors++; if (lat != int'(e[33:25])) begin miscompares++; $display("FAIL known_latency seed=%0d got %0d want %0d", k_seed[i], lat, e[33:25]); end
            vectors++; if (bc != e_bc) begin miscompares++; $display("FAIL known_busy seed=%0d got %0d want %0d", k_seed[i], bc, e_bc); end
            vectors++; if (o_err !== e[24]) begin miscompares++; $display("FAIL known_err seed=%0d got %b want %b", k_seed[i], o_err, e[24]); end
            vectors++; if (o_steps !== e[23:16]) begin miscompares++; $display("FAIL known_steps seed=%0d got %0d want %0d", k_seed[i], o_steps, e[23:16]); end
            vectors++; if (o_peak !== e[15:0]) begin miscompares++; $display("FAIL known_peak seed=%0d got %0d want %0d", k_seed[i], o_peak, e[15:0]); end
        end
    endtask

    task automatic test_random_seeds;
        int seed, lat, bc;
        logic [SB_W-1:0] e;
        for (int i = 0; i < 12; i++) begin
            sel = (i < 8) ? 0 : 1;
            seed = $urandom_range(1, 255);
            exp_q.push_back(model(seed, (sel == 0) ? 16 : 8, 8));
            run_seed(8'(seed), -1, lat, bc);
            e = exp_q.pop_front();
            vectors++; if (lat != int'(e[33:25])) begin miscompares++; $display("FAIL rand_latency sel=%0d seed=%0d got %0d want %0d", sel, seed, lat, e[33:25]); end
            vectors++; if (o_err !== e[24]) begin miscompares++; $display("FAIL rand_err sel=%0d seed=%0d got %b want %b", sel, seed, o_err, e[24]); end
            vectors++; if (o_steps !== e[23:16]) begin miscompares++; $display("FAIL rand_steps sel=%0d seed=%0d got %0d want %0d", sel, seed, o_steps, e[23:16]); end
            vectors++; if (o_peak !== e[15:0]) begin miscompares++; $display("FAIL rand_peak sel=%0d seed=%0d got %0d want %0d", sel, seed, o_peak, e[15:0]); end
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic [SB_W-1:0] e;
        sel = 0;
        exp_q.push_back(model(5, 16, 8));
        run_seed(8'd5, -1, lat, bc);
        e = exp_q.pop_front();
        vectors++; if (lat != int'(e[33:25])) begin miscompares++; $display("FAIL b2b_latency got %0d want %0d", lat, e[33:25]); end
        sv = 8'd9;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL start_in_done busy cyc=%0d got %b want 0", c, o_busy); end
            vectors++; if ({o_err, o_steps, o_peak} !== e[24:0]) begin miscompares++; $display("FAIL hold_results cyc=%0d got %h want %h", c, {o_err, o_steps, o_peak}, e[24:0]); end
            @(negedge clk);
        end
        exp_q.push_back(model(7, 16, 8));
        run_seed(8'd7, -1, lat, bc);
        e = exp_q.pop_front();
        vectors++; if (lat != int'(e[33:25])) begin miscompares++; $display("FAIL b2b2_latency got %0d want %0d", lat, e[33:25]); end
        vectors++; if ({o_err, o_steps, o_peak} !== e[24:0]) begin miscompares++; $display("FAIL b2b2_results got %h want %h", {o_err, o_steps, o_peak}, e[24:0]); end
    endtask

    task automatic test_reset_mid_run;
        int lat, bc;
        logic [SB_W-1:0] e;
        sel = 0;
        @(negedge clk);
        sv = 8'd27;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL midrun_busy got %b want 1", o_busy); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({o_busy, o_done, o_err} !== 3'b000) begin miscompares++; $display("FAIL async_reset_flags got %b want 000", {o_busy, o_done, o_err}); end
        vectors++; if (o_steps !== 8'd0) begin miscompares++; $display("FAIL async_reset_steps got %0d want 0", o_steps); end
        vectors++; if (o_peak !== 16'd0) begin miscompares++; $display("FAIL async_reset_peak got %0d want 0", o_peak); end
        vectors++; if (o_fsm !== 2'(ST_IDLE)) begin miscompares++; $display("FAIL async_reset_state got %0d want 0", o_fsm); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({9'd10, 1'b0, 8'd8, 16'd16});
        run_seed(8'd6, -1, lat, bc);
        e = exp_q.pop_front();
        vectors++; if (lat != int'(e[33:25])) begin miscompares++; $display("FAIL post_reset_latency got %0d want %0d", lat, e[33:25]); end
        vectors++; if ({o_err, o_steps, o_peak} !== e[24:0]) begin miscompares++; $display("FAIL post_reset_results got %h want %h", {o_err, o_steps, o_peak}, e[24:0]); end
    endtask

    initial begin
        test_reset();
        test_known_seeds();
        test_random_seeds();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/collatz_sequencer.md
COLLATZ_SEQUENCER -- requirements
Module: collatz_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the width of the internal value register and of peak.
REQ-002 SHALL have parameter STEP_W, default 8, meaning the width of the step counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request to run a sequence; sampled only in IDLE.
REQ-006 SHALL have port start_value  input  8  seed n0, captured on accept.
REQ-007 SHALL have port busy  output  1  high in RUN.
REQ-008 SHALL have port done  output  1  one-cycle pulse in DONE.
REQ-009 SHALL have port steps  output  STEP_W  number of steps taken to reach 1.
REQ-010 SHALL have port peak  output  WIDTH  largest value visited, including n0.
REQ-011 SHALL have port err  output  1  set when the run was invalid: zero seed, overflow, or step saturation.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start with start_value!=0; IDLE->DONE on start with start_value==0; RUN->DONE on termination; DONE->IDLE always after 1 cycle.
REQ-013 SHALL, on accept in cycle T: cur<=start_value (zero-extended), steps<=0, peak<=start_value, err<=0.
REQ-014 SHALL, in each RUN cycle with cur==1, go to DONE with no step; otherwise apply one step: even -> cur>>1, odd -> 3*cur+1, and increment steps.
REQ-015 SHALL update peak to the step result whenever that result exceeds peak, in the same cycle.
REQ-016 SHALL compute 3*cur+1 at WIDTH+2 bits; a result above 2^WIDTH-1 sets err, leaves cur/peak unchanged, and goes to DONE.
REQ-017 SHALL set err and go to DONE when steps equals 2^STEP_W-1 and cur!=1; steps does not wrap.
REQ-018 SHALL have a seed with k steps produce done high in cycle T+2+k; seed 1 gives done in T+2.
REQ-019 SHALL, on zero seed, produce done in T+1 with err=1, steps=0, peak=0.
REQ-020 SHALL ignore start while busy or done is high.
REQ-021 SHALL hold steps, peak and err stable from the done pulse until the next accepted start.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-RUN, immediately force state IDLE, busy=0, done=0, err=0, steps=0, peak=0, cur=0.
REQ-023 SHALL accept a start no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-024 SHALL take the state encoding (IDLE/RUN/DONE) and the default WIDTH/STEP_W constants from a shared package collatz_pkg.
REQ-025 SHALL place the single step function (==1 hold, even halve, odd 3n+1, plus an overflow flag) in sub-module collatz_step, combinational, width-parameterised.
REQ-026 SHALL register all outputs; no combinational path from start or start_value to any output.

Verification
REQ-027 SHALL cover: seed 1 -> done at T+2, steps=0, peak=1, err=0.
REQ-028 SHALL cover: seed 6 -> done at T+10, steps=8, peak=16, err=0; busy high T+1..T+9.
REQ-029 SHALL cover: seed 27 -> steps=111, peak=9232, err=0; a start pulsed during RUN has no effect.
REQ-030 SHALL cover: seed 0 -> done at T+1, err=1, steps=0, peak=0.
REQ-031 SHALL cover: WIDTH=8, seed 27 -> err=1 on 107->322 overflow, peak=214, steps=11.
REQ-032 SHALL cover: rst_n low at T+5 during seed 27 -> all outputs zero asynchronously; a new seed 6 then completes normally.
